wb_regfile_retire: RTL and testbench
====================================

Name: wb_regfile_retire

Overview:
- Parametrised writeback/retire stage: accepts one completed instruction per cycle from EX/MEM over a valid/ready handshake and commits it to the architectural register file.
- Commits up to WPORTS register writes per instruction (e.g. RAX+RDX for MUL), plus an implicit stack-pointer adjust.
- Holds an instruction until the memory stage acknowledges its store, and keeps a per-register busy scoreboard for decode hazard checks.
- Replaces the combinational writeback with a clocked, stallable retire point.

Parameters:
- XLEN, 64, data width of each register.
- NREGS, 16, number of architectural registers; RIDX = $clog2(NREGS).
- WPORTS, 2, register writes per committed instruction.
- SP_IDX, 4, index of the stack-pointer register.
- SP_STEP, 8, byte step for push/pop adjust.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM offers a completed instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_wen  in  WPORTS  per-port write enable.
- in_widx  in  WPORTS*RIDX  per-port destination index; port p occupies bits [p*RIDX +: RIDX].
- in_wdata  in  WPORTS*XLEN  per-port write data.
- in_sp_op  in  2  stack adjust: 0 none, 1 +SP_STEP, 2 -SP_STEP, 3 reserved (treated as none).
- in_store  in  1  instruction carries a memory store needing acknowledgement.
- in_halt  in  1  end-of-simulation marker.
- store_ack  in  1  memory stage has completed the pending store.
- claim_valid  in  1  decode claims a destination register.
- claim_idx  in  RIDX  claimed register index.
- store_commit  out  1  one-cycle pulse when a store instruction retires.
- busy  out  NREGS  scoreboard; bit r set means a write to r is in flight.
- regfile  out  NREGS*XLEN  architectural registers, flat; reg r occupies bits [r*XLEN +: XLEN].
- retired_count  out  32  committed-instruction counter.
- halted  out  1  a halt instruction has retired.

Behaviour:
- Reset (async, reset_n=0):
  - all regfile entries 0, busy 0, retired_count 0, store_commit 0, halted 0;
  - FSM to IDLE; any held instruction is discarded.
- FSM states IDLE, WAIT_STORE, HALTED.
- IDLE:
  - in_ready=1; acceptance = in_valid & in_ready.
  - On acceptance with in_store=0, or with in_store=1 and store_ack=1 in the same cycle: commit at that clock edge (latency 1 cycle to visible regfile).
  - On acceptance with in_store=1 and store_ack=0: latch the instruction into the hold register and go to WAIT_STORE.
- WAIT_STORE:
  - in_ready=0.
  - On store_ack=1: commit the held instruction and return to IDLE, or go to HALTED if it is a halt.
- HALTED: in_ready=0; all inputs except claim are ignored; leaves only on reset.
- Commit, in one edge:
  - For each p with in_wen[p]=1: regfile[in_widx[p]] <= in_wdata[p].
  - Two ports writing the same index: the highest port wins.
  - sp_op is applied to the pre-commit SP value, modulo 2^XLEN.
  - A port write to SP_IDX overrides sp_op in the same commit (POP into SP).
  - retired_count +1, wrapping at 2^32.
  - store_commit=1 for exactly the commit cycle when in_store=1.
  - If in_halt=1: halted=1 and next state is HALTED.
- Scoreboard:
  - claim_valid sets busy[claim_idx] at the edge.
  - A commit clears busy for every written index.
  - A simultaneous claim and clear on the same index leaves it set (the newer claim wins).
  - Claims are accepted in every state.
- in_wen=0 with in_sp_op=0 is a legal no-op commit (NOP/CMP/branch): only the counter advances.

Decomposition:
- Shared package wb_pkg holds:
  - wb_state_e enum {IDLE, WAIT_STORE, HALTED};
  - sp_op_e enum;
  - packed struct wb_req_t (wen, widx, wdata, sp_op, store, halt), which is also the hold-register type.
- One sub-module, wb_scoreboard: busy bit vector with set/clear priority logic.

Test Plan:
- Reset release, then accept {wen=01, widx0=3, wdata0=0x1234} -> next cycle regfile[3]=0x1234, retired_count=1, busy[3] cleared.
- Two-port commit {wen=11, idx 0/2, data 0xA/0xB}; then repeat with both ports at idx 5 (0xA/0xB) -> regfile[0]=0xA, regfile[2]=0xB; then regfile[5]=0xB (port 1 wins).
- SP=0x1000, push (sp_op=2) -> SP=0xFF8; pop with wen=01 to SP_IDX, data 0x7 -> SP=0x7 (port overrides adjust).
- Store accepted with store_ack=0 for 3 cycles -> in_ready=0 for those cycles, no regfile change, store_commit pulses once on the ack cycle, then in_ready=1.
- claim_idx=6 in the same cycle as a commit to reg 6 -> busy[6] stays 1; the next commit to reg 6 clears it.
- Halt retires -> halted=1 and in_ready=0 permanently; reset_n pulsed low while in WAIT_STORE -> all outputs 0 and state IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback/retire stage: FSM states, stack-adjust
// opcodes and the request record that is also used as the hold register.
package wb_pkg;

    // Default geometry. The request struct is sized from these constants,
    // so top-level parameter overrides must be matched here.
    localparam int WB_XLEN   = 64;
    localparam int WB_NREGS  = 16;
    localparam int WB_WPORTS = 2;
    localparam int WB_RIDX   = $clog2(WB_NREGS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_STORE = 2'd1,
        HALTED     = 2'd2
    } wb_state_e;

    // Stack-pointer adjust carried with each instruction; code 3 is reserved
    // and behaves like SP_NONE.
    typedef enum logic [1:0] {
        SP_NONE = 2'd0,
        SP_INC  = 2'd1,
        SP_DEC  = 2'd2,
        SP_RSVD = 2'd3
    } sp_op_e;

    // One completed instruction as offered by EX/MEM.
    typedef struct packed {
        logic [WB_WPORTS-1:0]         wen;
        logic [WB_WPORTS*WB_RIDX-1:0] widx;
        logic [WB_WPORTS*WB_XLEN-1:0] wdata;
        sp_op_e                       sp_op;
        logic                         store;
        logic                         halt;
    } wb_req_t;

    // True when the opcode actually moves the stack pointer.
    function automatic logic sp_active(input sp_op_e op);
        return (op == SP_INC) || (op == SP_DEC);
    endfunction

    // Stack pointer after the adjust, wrapping modulo 2^XLEN.
    function automatic logic [WB_XLEN-1:0] sp_adjust(
        input logic [WB_XLEN-1:0] sp,
        input sp_op_e             op,
        input logic [WB_XLEN-1:0] step
    );
        case (op)
            SP_INC:  return sp + step;
            SP_DEC:  return sp - step;
            default: return sp;
        endcase
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register busy bits for decode hazard checks. A claim sets a bit, a
// retiring write clears it; a claim arriving on the same edge as the clear
// is the newer producer and therefore keeps the bit set.
module wb_scoreboard #(
    parameter int NREGS = 16,
    parameter int RIDX  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             claim_valid,
    input  logic [RIDX-1:0]  claim_idx,
    input  logic [NREGS-1:0] clear_mask,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic [NREGS-1:0] claim_mask;

    // Decode the claim index into a one-hot set mask.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_claim
        assign claim_mask[gi] = claim_valid && (claim_idx == RIDX'(gi));
    end

    // Clear first, then set, so a same-edge claim overrides the retire.
    always_comb begin
        busy_next = (busy_reg & ~clear_mask) | claim_mask;
    end

    // Busy vector storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy = busy_reg;

endmodule

// File: rtl/wb_regfile_retire.sv
// Writeback/retire stage: accepts one completed instruction per cycle,
// holds store-carrying instructions until the memory stage acknowledges,
// and commits port writes plus the implicit stack adjust to the
// architectural register file on a single clock edge.
module wb_regfile_retire
    import wb_pkg::*;
#(
    parameter int XLEN    = WB_XLEN,
    parameter int NREGS   = WB_NREGS,
    parameter int WPORTS  = WB_WPORTS,
    parameter int SP_IDX  = 4,
    parameter int SP_STEP = 8,
    parameter int RIDX    = $clog2(NREGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WPORTS-1:0]        in_wen,
    input  logic [WPORTS*RIDX-1:0]   in_widx,
    input  logic [WPORTS*XLEN-1:0]   in_wdata,
    input  logic [1:0]               in_sp_op,
    input  logic                     in_store,
    input  logic                     in_halt,
    input  logic                     store_ack,
    input  logic                     claim_valid,
    input  logic [RIDX-1:0]          claim_idx,
    output logic                     store_commit,
    output logic [NREGS-1:0]         busy,
    output logic [NREGS*XLEN-1:0]    regfile,
    output logic [31:0]              retired_count,
    output logic                     halted
);

    wb_state_e        state_reg;
    wb_req_t          hold_reg;
    wb_req_t          in_req;
    wb_req_t          commit_req;
    logic             commit_en;
    logic             hold_en;
    logic [NREGS-1:0] clear_mask;
    logic [31:0]      retired_count_reg;
    logic             store_commit_reg;
    logic             halted_reg;

    // Bundle the input ports into the request record.
    always_comb begin
        in_req.wen   = in_wen;
        in_req.widx  = in_widx;
        in_req.wdata = in_wdata;
        in_req.sp_op = sp_op_e'(in_sp_op);
        in_req.store = in_store;
        in_req.halt  = in_halt;
    end

    // Only IDLE takes new work; WAIT_STORE and HALTED both backpressure.
    assign in_ready = (state_reg == IDLE);

    // Decide whether this edge commits, and from which source, or parks
    // the incoming instruction in the hold register.
    always_comb begin
        commit_en  = 1'b0;
        hold_en    = 1'b0;
        commit_req = in_req;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (!in_req.store || store_ack) begin
                        commit_en = 1'b1;
                    end else begin
                        hold_en = 1'b1;
                    end
                end
            end
            WAIT_STORE: begin
                commit_req = hold_reg;
                commit_en  = store_ack;
            end
            default: begin
                commit_en = 1'b0;
            end
        endcase
    end

    // Hold register for a store waiting on its acknowledgement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg <= '0;
        end else if (hold_en) begin
            hold_reg <= in_req;
        end
    end

    // One storage element per architectural register. Each register
    // resolves its own next value: the stack adjust is applied first from
    // the pre-commit value, then port writes in ascending order so that a
    // higher port, and any port write to SP, takes precedence.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        logic [XLEN-1:0] val_reg;
        logic [XLEN-1:0] val_next;
        logic            written;

        // Next-value selection for this register.
        always_comb begin
            val_next = val_reg;
            written  = 1'b0;
            if (commit_en) begin
                if ((gi == SP_IDX) && sp_active(commit_req.sp_op)) begin
                    val_next = sp_adjust(val_reg, commit_req.sp_op, XLEN'(SP_STEP));
                    written  = 1'b1;
                end
                for (int p = 0; p < WPORTS; p++) begin
                    if (commit_req.wen[p] &&
                        (commit_req.widx[p*RIDX +: RIDX] == RIDX'(gi))) begin
                        val_next = commit_req.wdata[p*XLEN +: XLEN];
                        written  = 1'b1;
                    end
                end
            end
        end

        // Register storage.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                val_reg <= '0;
            end else begin
                val_reg <= val_next;
            end
        end

        assign clear_mask[gi]            = written;
        assign regfile[gi*XLEN +: XLEN]  = val_reg;
    end

    // Retire FSM with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            retired_count_reg <= '0;
            store_commit_reg  <= 1'b0;
            halted_reg        <= 1'b0;
        end else begin
            store_commit_reg <= commit_en && commit_req.store;
            if (commit_en) begin
                retired_count_reg <= retired_count_reg + 32'd1;
            end
            case (state_reg)
                IDLE: begin
                    if (hold_en) begin
                        state_reg <= WAIT_STORE;
                    end else if (commit_en && commit_req.halt) begin
                        state_reg  <= HALTED;
                        halted_reg <= 1'b1;
                    end
                end
                WAIT_STORE: begin
                    if (commit_en) begin
                        if (commit_req.halt) begin
                            state_reg  <= HALTED;
                            halted_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                HALTED: begin
                    state_reg <= HALTED;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Busy scoreboard: claims from decode, clears from retiring writes.
    wb_scoreboard #(
        .NREGS (NREGS),
        .RIDX  (RIDX)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .claim_valid (claim_valid),
        .claim_idx   (claim_idx),
        .clear_mask  (clear_mask),
        .busy        (busy)
    );

    assign retired_count = retired_count_reg;
    assign store_commit  = store_commit_reg;
    assign halted        = halted_reg;

endmodule

// File: tb/tb_wb_regfile_retire.sv
// Bench for wb_regfile_retire: directed scenarios followed by a random
// phase, all checked every cycle against an instruction-level model.
module tb_wb_regfile_retire;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_wen = '0;
    logic [7:0]    in_widx = '0;
    logic [127:0]  in_wdata = '0;
    logic [1:0]    in_sp_op = '0;
    logic          in_store = 1'b0;
    logic          in_halt = 1'b0;
    logic          store_ack = 1'b0;
    logic          claim_valid = 1'b0;
    logic [3:0]    claim_idx = '0;
    logic          store_commit;
    logic [15:0]   busy;
    logic [1023:0] regfile;
    logic [31:0]   retired_count;
    logic          halted;

    int total = 0;
    int bad = 0;

    typedef struct {
        bit [1:0]  wen;
        bit [3:0]  idx0;
        bit [3:0]  idx1;
        bit [63:0] d0;
        bit [63:0] d1;
        bit [1:0]  sp;
        bit        store;
        bit        halt;
    } req_t;

    // Reference model state.
    logic [63:0] m_regs [16];
    logic [15:0] m_busy;
    logic [31:0] m_count;
    bit          m_halted;
    bit          m_store_commit;
    req_t        hold_q [$];
    req_t        cur;

    wb_regfile_retire dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wen        (in_wen),
        .in_widx       (in_widx),
        .in_wdata      (in_wdata),
        .in_sp_op      (in_sp_op),
        .in_store      (in_store),
        .in_halt       (in_halt),
        .store_ack     (store_ack),
        .claim_valid   (claim_valid),
        .claim_idx     (claim_idx),
        .store_commit  (store_commit),
        .busy          (busy),
        .regfile       (regfile),
        .retired_count (retired_count),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1023:0] m_flat();
        logic [1023:0] f;
        for (int r = 0; r < 16; r++) f[r*64 +: 64] = m_regs[r];
        return f;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) m_regs[r] = '0;
        m_busy = '0;
        m_count = '0;
        m_halted = 0;
        m_store_commit = 0;
        hold_q.delete();
    endtask

    task automatic check_all();
        chk("regfile", regfile, m_flat());
        chk("busy", busy, m_busy);
        chk("retired_count", retired_count, m_count);
        chk("halted", halted, m_halted);
        chk("store_commit", store_commit, m_store_commit);
        chk("in_ready", in_ready, (!m_halted && hold_q.size() == 0));
    endtask

    // Architectural effect of retiring one instruction.
    task automatic model_commit(input req_t r, inout logic [15:0] written);
        logic [63:0] sp_before;
        sp_before = m_regs[4];
        if (r.sp == 2'd1) begin m_regs[4] = sp_before + 64'd8; written[4] = 1'b1; end
        if (r.sp == 2'd2) begin m_regs[4] = sp_before - 64'd8; written[4] = 1'b1; end
        if (r.wen[0]) begin m_regs[r.idx0] = r.d0; written[r.idx0] = 1'b1; end
        if (r.wen[1]) begin m_regs[r.idx1] = r.d1; written[r.idx1] = 1'b1; end
        m_count = m_count + 32'd1;
        m_store_commit = r.store;
        if (r.halt) m_halted = 1;
        $display("retire #%0d wen=%b idx=%0d/%0d sp=%0d store=%0d halt=%0d",
                 m_count, r.wen, r.idx0, r.idx1, r.sp, r.store, r.halt);
    endtask

    task automatic drive(input req_t r, input bit valid);
        cur      = r;
        in_valid = valid;
        in_wen   = r.wen;
        in_widx  = {r.idx1, r.idx0};
        in_wdata = {r.d1, r.d0};
        in_sp_op = r.sp;
        in_store = r.store;
        in_halt  = r.halt;
    endtask

    function automatic req_t mk(input bit [1:0] wen, input bit [3:0] i0, input bit [63:0] d0,
                                input bit [3:0] i1, input bit [63:0] d1, input bit [1:0] sp,
                                input bit store, input bit halt);
        req_t r;
        r.wen = wen; r.idx0 = i0; r.d0 = d0; r.idx1 = i1; r.d1 = d1;
        r.sp = sp; r.store = store; r.halt = halt;
        return r;
    endfunction

    // Advance one clock: predict with the model, then compare after the edge.
    task automatic step();
        logic [15:0] written;
        written = '0;
        m_store_commit = 0;
        if (!m_halted) begin
            if (hold_q.size() > 0) begin
                if (store_ack) begin
                    model_commit(hold_q[0], written);
                    void'(hold_q.pop_front());
                end
            end else if (in_valid) begin
                if (!cur.store || store_ack) model_commit(cur, written);
                else hold_q.push_back(cur);
            end
        end
        m_busy = m_busy & ~written;
        if (claim_valid) m_busy[claim_idx] = 1'b1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    req_t idle_req;
    req_t r;

    initial begin
        idle_req = mk(2'b00, 0, 0, 0, 0, 0, 0, 0);
        drive(idle_req, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        // Claim r3, then a single-port write to r3 clears it.
        claim_valid = 1; claim_idx = 4'd3;
        step();
        claim_valid = 0;
        drive(mk(2'b01, 3, 64'h1234, 0, 0, 0, 0, 0), 1);
        step();

        // Two distinct ports, then both ports on r5 (port 1 wins).
        drive(mk(2'b11, 0, 64'hA, 2, 64'hB, 0, 0, 0), 1);
        step();
        drive(mk(2'b11, 5, 64'hA, 5, 64'hB, 0, 0, 0), 1);
        step();

        // SP setup, push, then pop into SP overriding the adjust.
        drive(mk(2'b01, 4, 64'h1000, 0, 0, 0, 0, 0), 1);
        step();
        drive(mk(2'b00, 0, 0, 0, 0, 2, 0, 0), 1);
        step();
        drive(mk(2'b01, 4, 64'h7, 0, 0, 1, 0, 0), 1);
        step();
        // Push from zero wraps modulo 2^64.
        drive(mk(2'b01, 4, 64'h0, 0, 0, 0, 0, 0), 1);
        step();
        drive(mk(2'b00, 0, 0, 0, 0, 2, 0, 0), 1);
        step();
        // Reserved sp_op and an empty commit only advance the counter.
        drive(mk(2'b00, 0, 0, 0, 0, 3, 0, 0), 1);
        step();

        // Store held for three cycles, then acknowledged.
        store_ack = 0;
        drive(mk(2'b01, 9, 64'h55, 0, 0, 0, 1, 0), 1);
        step();
        drive(idle_req, 0);
        step();
        step();
        store_ack = 1;
        step();
        store_ack = 0;
        step();

        // Claim and retire on r6 in the same edge: busy stays set.
        claim_valid = 1; claim_idx = 4'd6;
        drive(mk(2'b01, 6, 64'h66, 0, 0, 0, 0, 0), 1);
        step();
        claim_valid = 0;
        drive(mk(2'b10, 0, 0, 6, 64'h67, 0, 0, 0), 1);
        step();

        // Random phase.
        for (int i = 0; i < 400; i++) begin
            r = mk(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), {$urandom, $urandom},
                   4'($urandom_range(0, 15)), {$urandom, $urandom}, 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), 0);
            drive(r, ($urandom_range(0, 3) != 0));
            store_ack   = ($urandom_range(0, 2) == 0);
            claim_valid = ($urandom_range(0, 1) == 1);
            claim_idx   = 4'($urandom_range(0, 15));
            step();
        end
        claim_valid = 0;
        store_ack = 0;

        // Asynchronous reset while a store is pending.
        drive(idle_req, 0);
        step();
        drive(mk(2'b01, 7, 64'h77, 0, 0, 0, 1, 0), 1);
        step();
        drive(idle_req, 0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_all();

        // Halt retires, then all further inputs except claims are ignored.
        drive(mk(2'b01, 1, 64'h99, 0, 0, 0, 0, 1), 1);
        step();
        for (int i = 0; i < 6; i++) begin
            r = mk(2'b11, 4'($urandom_range(0, 15)), {$urandom, $urandom},
                   4'($urandom_range(0, 15)), {$urandom, $urandom}, 2'd2, 1'($urandom_range(0, 1)), 0);
            drive(r, 1);
            store_ack   = 1;
            claim_valid = 1;
            claim_idx   = 4'($urandom_range(0, 15));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
